// File: rtl/gps_wb_sequencer.sv
// rtl/gps_wb_sequencer.sv - Wishbone master running one GPS code-generation round per request
// Round: GO write, status poll, CLR write, reads of regs 1..9, then atomic code output update.
module gps_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_MAX    = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  output logic [12:0]  ca_code_o,
  output logic [127:0] p_code_o,
  output logic [127:0] l_code_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  output logic [3:0]   wbm_sel_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_POLL, S_CLR, S_RD, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d;
  logic            stb_q, stb_d, we_q, we_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [12:0]     ca_q, ca_d, ca_sh_q, ca_sh_d;
  logic [127:0]    p_q, p_d, l_q, l_d;
  logic [6:0][31:0] sh_q, sh_d;
  logic [3:0]      idx_q, idx_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic            poll_to_q, poll_to_d;

  function automatic logic [31:0] reg_addr(input logic [3:0] idx);
    return BASE_ADDR | {28'b0, idx};
  endfunction

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    ca_d       = ca_q;
    p_d        = p_q;
    l_d        = l_q;
    ca_sh_d    = ca_sh_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    ack_cnt_d  = ack_cnt_q;
    poll_cnt_d = poll_cnt_q;
    poll_to_d  = poll_to_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_GO;
          busy_d     = 1'b1;
          poll_cnt_d = '0;
          poll_to_d  = 1'b0;
          ack_cnt_d  = '0;
          stb_d      = 1'b1;
          adr_d      = reg_addr(4'd0);
          we_d       = 1'b1;
          dat_d      = 32'h1;
        end
      end
      S_GO, S_POLL, S_CLR, S_RD: begin
        if (!stb_q) begin
          // Idle gap after the previous response; launch this state's access.
          stb_d     = 1'b1;
          ack_cnt_d = '0;
          adr_d     = reg_addr((state_q == S_RD) ? idx_q : 4'd0);
          we_d      = (state_q == S_GO) || (state_q == S_CLR);
          dat_d     = {31'b0, state_q == S_GO};
        end else if (wbm_err_i || wbm_ack_i || (ack_cnt_q == AW'(ACK_TIMEOUT - 1))) begin
          stb_d = 1'b0;
          adr_d = '0;
          we_d  = 1'b0;
          dat_d = '0;
          if (wbm_err_i) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (!wbm_ack_i) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            case (state_q)
              S_GO: state_d = S_POLL;
              S_POLL: begin
                if (wbm_dat_i[0]) begin
                  state_d = S_CLR;
                end else if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                  poll_to_d = 1'b1;
                  state_d   = S_CLR;
                end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
                end
              end
              S_CLR: begin
                if (poll_to_q) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  err_code_d = 2'b11;
                end else begin
                  state_d = S_RD;
                  idx_d   = 4'd1;
                end
              end
              default: begin
                // Regs 2..8 shift in from the top; reg9 goes straight to the outputs.
                if (idx_q == 4'd9) begin
                  ca_d    = ca_sh_q;
                  p_d     = {sh_q[3], sh_q[2], sh_q[1], sh_q[0]};
                  l_d     = {wbm_dat_i, sh_q[6], sh_q[5], sh_q[4]};
                  done_d  = 1'b1;
                  state_d = S_DONE;
                end else begin
                  if (idx_q == 4'd1) ca_sh_d = wbm_dat_i[12:0];
                  else sh_d = {wbm_dat_i, sh_q[6:1]};
                  idx_d = idx_q + 4'd1;
                end
              end
            endcase
          end
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      ca_q       <= '0;
      p_q        <= '0;
      l_q        <= '0;
      ca_sh_q    <= '0;
      sh_q       <= '0;
      idx_q      <= '0;
      ack_cnt_q  <= '0;
      poll_cnt_q <= '0;
      poll_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      ca_q       <= ca_d;
      p_q        <= p_d;
      l_q        <= l_d;
      ca_sh_q    <= ca_sh_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      ack_cnt_q  <= ack_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      poll_to_q  <= poll_to_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign ca_code_o  = ca_q;
  assign p_code_o   = p_q;
  assign l_code_o   = l_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = 4'hF;
  assign wbm_cyc_o  = stb_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = we_q;
endmodule

// File: tb/tb_gps_wb_sequencer.sv
// tb/tb_gps_wb_sequencer.sv - self-checking bench for gps_wb_sequencer
// Behavioural Wishbone slave plus a round-level model of transactions, outcome and code outputs.
module tb_gps_wb_sequencer;
  localparam int PM = 4;
  localparam int AT = 16;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic         busy, done, err, cyc, stb, we;
  logic [1:0]   err_code;
  logic [12:0]  ca;
  logic [127:0] p_code, l_code;
  logic [31:0]  adr, dat_o;
  logic [3:0]   sel;
  logic [31:0]  dat_i = '0;
  logic         ack_i = 1'b0, err_i = 1'b0;

  int checks = 0, failures = 0;

  gps_wb_sequencer #(.BASE_ADDR(32'h0), .ACK_TIMEOUT(AT), .POLL_MAX(PM)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
    .ca_code_o(ca), .p_code_o(p_code), .l_code_o(l_code),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_cyc_o(cyc),
    .wbm_stb_o(stb), .wbm_we_o(we), .wbm_dat_i(dat_i), .wbm_ack_i(ack_i), .wbm_err_i(err_i)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  logic [31:0] reg_val [1:9];
  int  p_inv = 0, err_k = -1, hang_k = -1, max_delay = 0;
  int  txn_idx = 0, wait_cnt = 0, cur_delay = 0, poll_reads = 0, hang_cnt = 0, viol = 0, delay_sum = 0;
  bit  resp_prev = 1'b0;
  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];

  logic [12:0]  exp_ca = '0;
  logic [127:0] exp_p = '0, exp_l = '0;

  // Slave: responds after cur_delay wait cycles, can hang or error on a chosen transaction.
  always @(negedge clk) begin
    logic [31:0] rnd;
    int ri;
    if (rst) begin
      ack_i = 1'b0; err_i = 1'b0; resp_prev = 1'b0;
    end else begin
      if (cyc !== stb || sel !== 4'hF) viol++;
      if (stb === 1'b1 && resp_prev) viol++;
      resp_prev = 1'b0; ack_i = 1'b0; err_i = 1'b0;
      if (stb === 1'b1) begin
        if (txn_idx == hang_k) begin
          hang_cnt++;
        end else if (wait_cnt < cur_delay) begin
          wait_cnt++;
        end else begin
          log_adr.push_back(adr); log_we.push_back(we); log_dat.push_back(dat_o);
          if (txn_idx == err_k) begin
            err_i = 1'b1;
            ack_i = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
          end else begin
            ack_i = 1'b1;
            if (!we) begin
              ri = int'(adr[3:0]);
              if (ri == 0) begin
                rnd = $urandom;
                dat_i = {rnd[31:1], (poll_reads >= p_inv) ? 1'b1 : 1'b0};
                poll_reads++;
              end else if (ri <= 9) begin
                dat_i = reg_val[ri];
              end
            end
          end
          delay_sum += cur_delay;
          txn_idx++;
          wait_cnt = 0;
          cur_delay = $urandom_range(0, max_delay);
          resp_prev = 1'b1;
        end
      end
    end
  end

  task automatic rand_regs();
    for (int i = 1; i <= 9; i++) reg_val[i] = $urandom;
  endtask

  task automatic config_slave(input int p, input int ek, input int hk, input int md);
    p_inv = p; err_k = ek; hang_k = hk; max_delay = md;
    txn_idx = 0; wait_cnt = 0; poll_reads = 0; hang_cnt = 0; viol = 0; delay_sum = 0;
    cur_delay = $urandom_range(0, md);
    log_adr.delete(); log_we.delete(); log_dat.delete();
  endtask

  task automatic model_load();
    exp_ca = reg_val[1][12:0];
    exp_p  = {reg_val[5], reg_val[4], reg_val[3], reg_val[2]};
    exp_l  = {reg_val[9], reg_val[8], reg_val[7], reg_val[6]};
  endtask

  task automatic do_round(input string name, input int p, input int ek, input int hk, input int md);
    logic [31:0] ea[$];
    logic        ew[$];
    logic [31:0] ed[$];
    int npoll, keep, exp_code, t0, tend, busy_low, bad;
    bit got_done, got_err;

    config_slave(p, ek, hk, md);
    npoll = (p < PM) ? p + 1 : PM;
    ea.push_back(32'd0); ew.push_back(1'b1); ed.push_back(32'd1);
    for (int i = 0; i < npoll; i++) begin ea.push_back(32'd0); ew.push_back(1'b0); ed.push_back(32'd0); end
    ea.push_back(32'd0); ew.push_back(1'b1); ed.push_back(32'd0);
    if (p < PM) for (int j = 1; j <= 9; j++) begin ea.push_back(32'(j)); ew.push_back(1'b0); ed.push_back(32'd0); end
    keep = ea.size();
    if (ek >= 0) begin keep = ek + 1; exp_code = 1; end
    else if (hk >= 0) begin keep = hk; exp_code = 2; end
    else if (p >= PM) exp_code = 3;
    else exp_code = 0;
    while (ea.size() > keep) begin void'(ea.pop_back()); void'(ew.pop_back()); void'(ed.pop_back()); end

    @(negedge clk); start = 1'b1; t0 = cyc_cnt;
    @(negedge clk); start = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    got_done = done; got_err = err; tend = cyc_cnt - t0;

    checks++;
    if (exp_code == 0 ? !(got_done && !got_err) : !(got_err && !got_done)) begin
      failures++;
      $display("FAIL %s outcome: done=%0b err=%0b, required %s", name, got_done, got_err, exp_code == 0 ? "done" : "err");
    end
    if (exp_code != 0) begin
      checks++;
      if (err_code !== 2'(exp_code)) begin
        failures++;
        $display("FAIL %s err_code: got %0d required %0d", name, err_code, exp_code);
      end
    end else begin
      checks++;
      if (tend != 24 + 2 * p + delay_sum) begin
        failures++;
        $display("FAIL %s done_cycle: got %0d required %0d", name, tend, 24 + 2 * p + delay_sum);
      end
      model_load();
    end
    checks++;
    if (busy_low != 0) begin
      failures++;
      $display("FAIL %s busy_during_round: %0d cycles low, required 0", name, busy_low);
    end
    checks++;
    if (ca !== exp_ca || p_code !== exp_p || l_code !== exp_l) begin
      failures++;
      $display("FAIL %s codes: ca=%h p=%h l=%h required ca=%h p=%h l=%h", name, ca, p_code, l_code, exp_ca, exp_p, exp_l);
    end

    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s after_end: busy=%b done=%b err=%b required 0 0 0", name, busy, done, err);
    end
    repeat (6) @(negedge clk);
    if (exp_code != 0) begin
      checks++;
      if (err_code !== 2'(exp_code)) begin
        failures++;
        $display("FAIL %s err_code_held: got %0d required %0d", name, err_code, exp_code);
      end
    end
    checks++;
    if (log_adr.size() != ea.size()) begin
      failures++;
      $display("FAIL %s txn_count: got %0d required %0d", name, log_adr.size(), ea.size());
    end
    bad = -1;
    for (int i = 0; i < ea.size() && i < log_adr.size(); i++)
      if (bad < 0 && (log_adr[i] !== ea[i] || log_we[i] !== ew[i] || log_dat[i] !== ed[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s txn[%0d]: adr=%h we=%b dat=%h required adr=%h we=%b dat=%h", name, bad,
               log_adr[bad], log_we[bad], log_dat[bad], ea[bad], ew[bad], ed[bad]);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL %s protocol: %0d violations, required 0", name, viol);
    end
    if (hk >= 0) begin
      checks++;
      if (hang_cnt != AT) begin
        failures++;
        $display("FAIL %s ack_timeout_len: stb high %0d cycles, required %0d", name, hang_cnt, AT);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (stb !== 1'b0 || cyc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== 2'b0 ||
        ca !== '0 || p_code !== '0 || l_code !== '0 || adr !== '0 || we !== 1'b0 || dat_o !== '0) begin
      failures++;
      $display("FAIL %s: stb=%b cyc=%b busy=%b done=%b err=%b code=%0d ca=%h adr=%h we=%b dat=%h p=%h l=%h, required all 0",
               name, stb, cyc, busy, done, err, err_code, ca, adr, we, dat_o, p_code, l_code);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    checks++;
    if (sel !== 4'hF) begin
      failures++;
      $display("FAIL reset_sel: got %h required f", sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    for (int i = 1; i <= 9; i++) reg_val[i] = 32'hA0 + 32'(i);
    do_round("latency", 0, -1, -1, 0);
    checks++;
    if (ca !== 13'h0A1 || p_code !== {32'hA5, 32'hA4, 32'hA3, 32'hA2} || l_code !== {32'hA9, 32'hA8, 32'hA7, 32'hA6}) begin
      failures++;
      $display("FAIL latency_literal: ca=%h p=%h l=%h", ca, p_code, l_code);
    end
  endtask

  task automatic test_polling();
    rand_regs();
    do_round("polling", 2, -1, -1, 0);
  endtask

  task automatic test_poll_timeout();
    rand_regs();
    do_round("poll_timeout", 1000, -1, -1, 0);
  endtask

  task automatic test_ack_timeout();
    rand_regs();
    do_round("ack_timeout_rd5", 0, -1, 7, 0);
  endtask

  task automatic test_slave_err();
    rand_regs();
    do_round("slave_err_rd3", 0, 5, -1, 0);
  endtask

  task automatic test_random();
    int p, mode, len, k;
    string nm;
    for (int r = 0; r < 10; r++) begin
      rand_regs();
      p = $urandom_range(0, 5);
      mode = $urandom_range(0, 5);
      len = (p < PM) ? p + 12 : PM + 2;
      k = $urandom_range(0, len - 1);
      nm = $sformatf("random%0d", r);
      if (mode == 0) do_round(nm, p, k, -1, $urandom_range(0, 3));
      else if (mode == 1) do_round(nm, p, -1, k, $urandom_range(0, 3));
      else do_round(nm, p, -1, -1, $urandom_range(0, 3));
    end
  endtask

  task automatic test_busy_start();
    int dones;
    rand_regs();
    config_slave(0, -1, -1, 0);
    @(negedge clk); start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 12 || i == 24) ? 1'b1 : 1'b0;
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    model_load();
    checks++;
    if (dones != 1 || log_adr.size() != 12 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start: dones=%0d txns=%0d busy=%b, required 1 12 0", dones, log_adr.size(), busy);
    end
    checks++;
    if (p_code !== exp_p || l_code !== exp_l || ca !== exp_ca) begin
      failures++;
      $display("FAIL busy_start_codes: p=%h required %h", p_code, exp_p);
    end
  endtask

  task automatic test_back_to_back();
    int t0, n, td[$];
    rand_regs();
    config_slave(0, -1, -1, 0);
    @(negedge clk); start = 1'b1; t0 = cyc_cnt;
    n = 0;
    for (int i = 0; i < 120 && td.size() < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) td.push_back(cyc_cnt - t0);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    model_load();
    checks++;
    if (td.size() != 2 || td[0] != 24 || td[1] != 49) begin
      failures++;
      $display("FAIL back_to_back_timing: %0d dones, first=%0d second=%0d, required 2 at 24 and 49",
               td.size(), td.size() > 0 ? td[0] : -1, td.size() > 1 ? td[1] : -1);
    end
    checks++;
    if (log_adr.size() != 24 || busy !== 1'b0 || viol != 0 || p_code !== exp_p) begin
      failures++;
      $display("FAIL back_to_back_txns: txns=%0d busy=%b viol=%0d, required 24 0 0", log_adr.size(), busy, viol);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    rand_regs();
    config_slave(0, -1, -1, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (stb === 1'b1 && we === 1'b0 && adr[3:0] == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_reach_rd5: never saw read of idx5, required within 60 cycles");
    end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_outputs");
    @(negedge clk);
    rst = 1'b0;
    exp_ca = '0; exp_p = '0; exp_l = '0;
    rand_regs();
    do_round("after_reset", 1, -1, -1, 1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_polling();
    test_poll_timeout();
    test_ack_timeout();
    test_slave_err();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
